// File: rtl/fpu_pkg.sv
// Shared FPU definitions: sequencer state encoding and default chunk geometry
// for the chunk-serial integer adder.
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } adder_seq_state_t;

  localparam int CHUNK_DEF  = 8;
  localparam int CHUNKS_DEF = 4;

endpackage

// File: rtl/adder.sv
// Parameterized unsigned adder: SIZE-bit sum plus carry out of the MSB.
module adder #(
  parameter int SIZE = 9
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] sum,
  output logic            carry
);

  assign {carry, sum} = a + b;

endmodule

// File: rtl/adder_rr_sequencer.sv
// Two-requester round-robin front end that runs each WIDTH-bit add through
// one shared CHUNK-bit adder, LSB chunk first, with a registered ripple carry.
module adder_rr_sequencer
  import fpu_pkg::*;
#(
  parameter int CHUNK  = CHUNK_DEF,
  parameter int CHUNKS = CHUNKS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [CHUNK*CHUNKS-1:0] a0,
  input  logic [CHUNK*CHUNKS-1:0] b0,
  input  logic [CHUNK*CHUNKS-1:0] a1,
  input  logic [CHUNK*CHUNKS-1:0] b1,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [CHUNK*CHUNKS-1:0] res_sum,
  output logic                    res_carry,
  output logic                    res_id
);

  localparam int WIDTH = CHUNK * CHUNKS;
  localparam int CNT_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHUNKS - 1);

  adder_seq_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry_reg;
  logic             last_grant;
  logic [WIDTH-1:0] op_a, op_b;
  logic [1:0]       grant;
  logic             accept;
  logic             gid;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   add_sum;
  logic             add_carry;

  assign a_chunk = op_a[cnt*CHUNK +: CHUNK];
  assign b_chunk = op_b[cnt*CHUNK +: CHUNK];

  // Forcing the LSB of A to 1 turns the registered carry into a real carry-in:
  // bit 0 of the sum is discarded and bits [CHUNK:1] are a + b + carry_reg.
  adder #(.SIZE(CHUNK + 1)) u_adder (
    .a     ({a_chunk, 1'b1}),
    .b     ({b_chunk, carry_reg}),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_comb begin
    state_nxt = state;
    grant     = 2'b00;
    case (state)
      IDLE: begin
        case (req_valid)
          2'b01:   grant = 2'b01;
          2'b10:   grant = 2'b10;
          2'b11:   grant = last_grant ? 2'b01 : 2'b10;
          default: grant = 2'b00;
        endcase
        if (|grant) state_nxt = RUN;
      end
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = grant;
  assign accept    = |grant;
  assign gid       = grant[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      res_valid  <= 1'b0;
      res_sum    <= '0;
      res_carry  <= 1'b0;
      res_id     <= 1'b0;
      cnt        <= '0;
      carry_reg  <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            res_id     <= gid;
            last_grant <= gid;
            carry_reg  <= 1'b0;
            cnt        <= '0;
          end
        end
        RUN: begin
          res_sum[cnt*CHUNK +: CHUNK] <= add_sum[CHUNK:1];
          carry_reg <= add_carry;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST) begin
            res_carry <= add_carry;
            res_valid <= 1'b1;
          end
        end
        DONE: if (res_ready) res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Operand capture is pure data and needs no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      op_a <= gid ? a1 : a0;
      op_b <= gid ? b1 : b0;
    end
  end

endmodule

// File: tb/tb_adder_rr_sequencer.sv
// Directed bench for adder_rr_sequencer with CHUNK=8, CHUNKS=4.
module tb_adder_rr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] a0, b0, a1, b1;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_sum;
  logic        res_carry;
  logic        res_id;

  int passed = 0;
  int total  = 0;

  adder_rr_sequencer #(.CHUNK(8), .CHUNKS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_carry (res_carry),
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (res_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Single uncontended op with res_ready high; checks grant, latency and result.
  task automatic run_one(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] es, input logic ec, input string tag);
    int lat;
    if (id == 0) begin a0 = a; b0 = b; req_valid = 2'b01; end
    else         begin a1 = a; b1 = b; req_valid = 2'b10; end
    #1;
    chk({tag, "_ready"}, req_ready, (id == 0) ? 2'b01 : 2'b10);
    tick();
    req_valid = 2'b00;
    wait_result(lat);
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_sum"}, res_sum, es);
    chk({tag, "_carry"}, res_carry, ec);
    chk({tag, "_id"}, res_id, id[0]);
    tick();
    chk({tag, "_drop"}, res_valid, 1'b0);
  endtask

  initial begin
    int lat, got, twohot, bad_out, bad_rdy, spurious;
    logic [31:0] sums [6];
    logic        ids  [6];

    reset = 1'b1; req_valid = 2'b00; res_ready = 1'b1;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    tick(); tick();
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_sum",   res_sum,   32'h0);
    chk("rst_carry", res_carry, 1'b0);
    chk("rst_id",    res_id,    1'b0);
    reset = 1'b0;
    #1;
    chk("rst_ready", req_ready, 2'b00);

    run_one(0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, "carry_all");
    run_one(0, 32'h00FF_00FF, 32'h0001_0001, 32'h0100_0100, 1'b0, "inter_chunk");
    run_one(1, 32'h8000_0000, 32'h8000_0001, 32'h0000_0001, 1'b1, "msb_wrap");

    // Contention straight after reset: requester 0 must win first.
    reset = 1'b1; tick(); reset = 1'b0;
    a0 = 32'd3; b0 = 32'd4; a1 = 32'd10; b1 = 32'd20;
    req_valid = 2'b11;
    #1;
    chk("cont_grant0", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    #1;
    chk("cont_busy_ready", req_ready, 2'b00);
    wait_result(lat);
    chk("cont_sum0", res_sum, 32'd7);
    chk("cont_id0",  res_id,  1'b0);
    tick();
    chk("cont_grant1", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    wait_result(lat);
    chk("cont_sum1", res_sum, 32'd30);
    chk("cont_id1",  res_id,  1'b1);
    tick();

    // Fairness: both held valid for six operations.
    a0 = 32'h1111_1111; b0 = 32'd1; a1 = 32'h2222_2222; b1 = 32'd2;
    req_valid = 2'b11;
    got = 0; twohot = 0;
    for (int c = 0; c < 100 && got < 6; c++) begin
      tick();
      if (req_ready == 2'b11) twohot++;
      if (res_valid === 1'b1) begin
        ids[got]  = res_id;
        sums[got] = res_sum;
        got++;
      end
    end
    req_valid = 2'b00;
    chk("fair_count", got, 6);
    chk("fair_twohot", twohot, 0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("fair_id%0d", i), ids[i], i % 2);
      chk($sformatf("fair_sum%0d", i), sums[i], (i % 2 == 0) ? 32'h1111_1112 : 32'h2222_2224);
    end
    tick();

    // Back-pressure: result held for five cycles, no grants while DONE.
    res_ready = 1'b0;
    a0 = 32'd5; b0 = 32'd6;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    wait_result(lat);
    chk("bp_sum", res_sum, 32'd11);
    a1 = 32'd100; b1 = 32'd1;
    req_valid = 2'b11;
    bad_out = 0; bad_rdy = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (res_valid !== 1'b1 || res_sum !== 32'd11 || res_id !== 1'b0 || res_carry !== 1'b0)
        bad_out++;
      if (req_ready !== 2'b00) bad_rdy++;
    end
    chk("bp_stable", bad_out, 0);
    chk("bp_no_ready", bad_rdy, 0);
    res_ready = 1'b1;
    tick();
    chk("bp_release_valid", res_valid, 1'b0);
    chk("bp_hold_sum", res_sum, 32'd11);
    chk("bp_next_grant", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    wait_result(lat);
    chk("bp_sum2", res_sum, 32'd101);
    chk("bp_id2",  res_id,  1'b1);
    tick();

    // Reset during chunk 2 of a requester-0 op.
    a0 = 32'h0101_0101; b0 = 32'h0101_0101;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick(); tick();
    reset = 1'b1;
    req_valid = 2'b11;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", res_valid, 1'b0);
    chk("mid_rst_sum",   res_sum,   32'h0);
    chk("mid_rst_carry", res_carry, 1'b0);
    chk("mid_rst_id",    res_id,    1'b0);
    chk("mid_rst_grant", req_ready, 2'b01);
    req_valid = 2'b00;
    spurious = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (res_valid !== 1'b0) spurious++;
    end
    chk("mid_rst_no_result", spurious, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
